// File: rtl/demux_frame_sequencer_pkg.sv
// demux_frame_pkg
// Shared types and constants for the serial frame front-end that feeds the
// 1:16 demultiplexer.
//   frame_state_t        : parser states (IDLE, ADDR, PAYLOAD, STOP)
//   ADDR_BITS            : width of the channel address carried in a frame
//   NUM_CHANNELS         : number of demux channels (2**ADDR_BITS)
//   DEFAULT_PAYLOAD_BITS : default payload length per frame
//   DEFAULT_GAP_LIMIT    : default mid-frame idle tolerance in cycles
package demux_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    STOP    = 2'd3
  } frame_state_t;

  localparam int ADDR_BITS            = 4;
  localparam int NUM_CHANNELS         = 16;
  localparam int DEFAULT_PAYLOAD_BITS = 8;
  localparam int DEFAULT_GAP_LIMIT    = 15;

endpackage

// File: rtl/demux_frame_sequencer_gap_timer.sv
// frame_gap_timer
// Counts consecutive idle cycles while a frame is in progress and flags the
// cycle in which the idle run reaches GAP_LIMIT.
//   clk     in  : clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   active  in  : a frame is in progress (parser not idle)
//   valid   in  : serial input carries a bit this cycle
//   timeout out : combinational; high during the GAP_LIMIT-th idle cycle
module frame_gap_timer #(
  parameter int GAP_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic valid,
  output logic timeout
);

  localparam int CW = $clog2(GAP_LIMIT + 1);
  // Value held by the counter during the idle cycle that completes the run.
  localparam logic [CW-1:0] COUNT_LAST = CW'(GAP_LIMIT - 1);

  logic [CW-1:0] count_reg;

  // A valid bit always wins: the timeout can only fire on an idle cycle.
  assign timeout = active && !valid && (count_reg == COUNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!active || valid || timeout) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/demux_frame_sequencer.sv
// demux_frame_sequencer
// Parses bit-serial frames (start=1, 4 address bits MSB first, PAYLOAD_BITS
// payload bits LSB first, stop=0) and drives the 1:16 demux so each payload
// bit lands on the addressed channel. Reports completion, drops to masked
// channels and framing errors (bad stop bit or mid-frame idle timeout).
//   Clock_In         in  : clock, rising edge
//   Reset_N_In       in  : asynchronous active-low reset
//   Serial_Valid_In  in  : qualifies Serial_Data_In
//   Serial_Data_In   in  : serial frame bit
//   Channel_Mask_In  in  : bit n=1 disables channel n (sampled at address end)
//   Enable_Out       out : demux enable, one pulse per delivered payload bit
//   Data_Out         out : demux data, 0 whenever Enable_Out is 0
//   Select_Out       out : demux channel select, held between frames
//   Busy_Out         out : frame in progress
//   Frame_Done_Out   out : pulse, good frame to an unmasked channel
//   Frame_Drop_Out   out : pulse, good frame to a masked channel
//   Frame_Error_Out  out : pulse, bad stop bit or gap timeout
module demux_frame_sequencer
  import demux_frame_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
  parameter int GAP_LIMIT    = DEFAULT_GAP_LIMIT
) (
  input  logic                    Clock_In,
  input  logic                    Reset_N_In,
  input  logic                    Serial_Valid_In,
  input  logic                    Serial_Data_In,
  input  logic [NUM_CHANNELS-1:0] Channel_Mask_In,
  output logic                    Enable_Out,
  output logic                    Data_Out,
  output logic [ADDR_BITS-1:0]    Select_Out,
  output logic                    Busy_Out,
  output logic                    Frame_Done_Out,
  output logic                    Frame_Drop_Out,
  output logic                    Frame_Error_Out
);

  localparam int PCW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [PCW-1:0] PAY_LAST = PCW'(PAYLOAD_BITS - 1);

  // The address shift register is seeded with a single marker 1 when the
  // start bit arrives. After three address bits the marker sits in the MSB,
  // which identifies the fourth bit without a separate bit counter.
  localparam logic [ADDR_BITS-1:0] ADDR_SEED = ADDR_BITS'(1);

  frame_state_t             state_reg, state_next;
  logic [ADDR_BITS-1:0]     addr_sh_reg, addr_sh_next;
  logic [PCW-1:0]           pay_cnt_reg, pay_cnt_next;
  logic                     mask_flag_reg, mask_flag_next;
  logic [ADDR_BITS-1:0]     select_reg, select_next;
  logic                     enable_reg, enable_next;
  logic                     data_reg, data_next;
  logic                     done_reg, done_next;
  logic                     drop_reg, drop_next;
  logic                     error_reg, error_next;
  logic                     timeout;
  logic [ADDR_BITS-1:0]     addr_full;

  assign addr_full = {addr_sh_reg[ADDR_BITS-2:0], Serial_Data_In};

  frame_gap_timer #(
    .GAP_LIMIT(GAP_LIMIT)
  ) u_gap_timer (
    .clk     (Clock_In),
    .rst_n   (Reset_N_In),
    .active  (state_reg != IDLE),
    .valid   (Serial_Valid_In),
    .timeout (timeout)
  );

  always_comb begin
    state_next     = state_reg;
    addr_sh_next   = addr_sh_reg;
    pay_cnt_next   = pay_cnt_reg;
    mask_flag_next = mask_flag_reg;
    select_next    = select_reg;
    enable_next    = 1'b0;
    data_next      = 1'b0;
    done_next      = 1'b0;
    drop_next      = 1'b0;
    error_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (Serial_Valid_In && Serial_Data_In) begin
          state_next   = ADDR;
          addr_sh_next = ADDR_SEED;
        end
      end
      ADDR: begin
        if (Serial_Valid_In) begin
          addr_sh_next = addr_full;
          if (addr_sh_reg[ADDR_BITS-1]) begin
            state_next     = PAYLOAD;
            select_next    = addr_full;
            mask_flag_next = Channel_Mask_In[addr_full];
            pay_cnt_next   = '0;
          end
        end
      end
      PAYLOAD: begin
        if (Serial_Valid_In) begin
          enable_next = !mask_flag_reg;
          data_next   = !mask_flag_reg && Serial_Data_In;
          if (pay_cnt_reg == PAY_LAST) begin
            state_next   = STOP;
            pay_cnt_next = '0;
          end else begin
            pay_cnt_next = pay_cnt_reg + PCW'(1);
          end
        end
      end
      STOP: begin
        if (Serial_Valid_In) begin
          state_next = IDLE;
          if (Serial_Data_In) begin
            error_next = 1'b1;
          end else if (mask_flag_reg) begin
            drop_next = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Timeout only fires on idle cycles, so it never collides with the
    // valid-bit transitions above.
    if (timeout) begin
      state_next   = IDLE;
      error_next   = 1'b1;
      pay_cnt_next = '0;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_reg     <= IDLE;
      addr_sh_reg   <= '0;
      pay_cnt_reg   <= '0;
      mask_flag_reg <= 1'b0;
      select_reg    <= '0;
      enable_reg    <= 1'b0;
      data_reg      <= 1'b0;
      done_reg      <= 1'b0;
      drop_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_sh_reg   <= addr_sh_next;
      pay_cnt_reg   <= pay_cnt_next;
      mask_flag_reg <= mask_flag_next;
      select_reg    <= select_next;
      enable_reg    <= enable_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
      drop_reg      <= drop_next;
      error_reg     <= error_next;
    end
  end

  assign Enable_Out      = enable_reg;
  assign Data_Out        = data_reg;
  assign Select_Out      = select_reg;
  assign Busy_Out        = (state_reg != IDLE);
  assign Frame_Done_Out  = done_reg;
  assign Frame_Drop_Out  = drop_reg;
  assign Frame_Error_Out = error_reg;

endmodule
